// File: rtl/commit_trace_pkg.sv
// rtl/commit_trace_pkg.sv - shared types and constants for the commit-trace buffer
package commit_trace_pkg;

  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } trace_state_t;

  typedef struct packed {
    logic [63:0] seq;
    logic [63:0] pre_pc;
    logic [63:0] pc;
    logic [31:0] instr;
  } trace_rec_t;

  localparam int REC_W = $bits(trace_rec_t);

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with level, full and empty
// Storage is cleared on reset so the head reads zero while nothing is queued.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic             push_ok;
  logic             pop_ok;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign pop_ok  = pop_i && !empty_o;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push_ok = push_i && (!full_o || pop_ok);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_ok && !pop_ok)      level_q <= level_q + (AW+1)'(1);
      else if (!push_ok && pop_ok) level_q <= level_q - (AW+1)'(1);
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/commit_trace_buf.sv
// rtl/commit_trace_buf.sv - retire trace FIFO with counters, ebreak halt and hang watchdog
module commit_trace_buf #(
  parameter int DEPTH       = 8,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   commit,
  input  logic [31:0]            commit_instr,
  input  logic [63:0]            commit_pc,
  input  logic [63:0]            commit_pre_pc,
  output logic                   trace_valid,
  input  logic                   trace_ready,
  output logic [63:0]            trace_seq,
  output logic [31:0]            trace_instr,
  output logic [63:0]            trace_pc,
  output logic [63:0]            trace_pre_pc,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [63:0]            retire_cnt,
  output logic [63:0]            cycle_cnt,
  output logic                   halted,
  output logic                   overflow,
  output logic                   hang
);

  import commit_trace_pkg::*;

  localparam int WW = $clog2(WDOG_CYCLES + 1);

  trace_state_t state_q, state_d;
  logic [63:0]  retire_cnt_q;
  logic [63:0]  cycle_cnt_q;
  logic [WW-1:0] wdog_q;
  logic         overflow_q;
  logic         hang_q;

  logic         retire;
  logic         pop;
  logic         push;
  logic         fifo_full;
  logic         fifo_empty;
  trace_rec_t   wr_rec;
  trace_rec_t   rd_rec;

  assign retire = (state_q == RUN) && commit;
  assign pop    = trace_valid && trace_ready;
  assign push   = retire && (!fifo_full || pop);

  assign wr_rec = '{seq: retire_cnt_q, pre_pc: commit_pre_pc, pc: commit_pc, instr: commit_instr};

  sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_rec),
    .rdata_o (rd_rec),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (retire && (commit_instr == EBREAK_INSTR)) state_d = DRAIN;
      // Leaves DRAIN on the edge after the registered level has reached zero.
      DRAIN:   if (fifo_level == '0) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= RUN;
      retire_cnt_q <= '0;
      cycle_cnt_q  <= '0;
      wdog_q       <= '0;
      overflow_q   <= 1'b0;
      hang_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q != HALTED) cycle_cnt_q <= cycle_cnt_q + 64'd1;
      if (retire) begin
        retire_cnt_q <= retire_cnt_q + 64'd1;
        if (!push) overflow_q <= 1'b1;
      end
      // Watchdog saturates at the limit; hang stays set until reset.
      if (retire) begin
        wdog_q <= '0;
      end else if ((state_q == RUN) && (wdog_q != WW'(WDOG_CYCLES))) begin
        wdog_q <= wdog_q + WW'(1);
        if (wdog_q == WW'(WDOG_CYCLES - 1)) hang_q <= 1'b1;
      end
    end
  end

  assign trace_valid  = !fifo_empty;
  assign trace_seq    = rd_rec.seq;
  assign trace_instr  = rd_rec.instr;
  assign trace_pc     = rd_rec.pc;
  assign trace_pre_pc = rd_rec.pre_pc;
  assign retire_cnt   = retire_cnt_q;
  assign cycle_cnt    = cycle_cnt_q;
  assign halted       = (state_q == HALTED);
  assign overflow     = overflow_q;
  assign hang         = hang_q;

endmodule

// File: tb/tb_commit_trace_buf.sv
// tb/tb_commit_trace_buf.sv - scoreboard bench for commit_trace_buf with a queue-based reference model
module tb_commit_trace_buf;

  localparam int DEPTH = 8;
  localparam int WDOG  = 16;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit;
  logic [31:0] commit_instr;
  logic [63:0] commit_pc;
  logic [63:0] commit_pre_pc;
  logic        trace_valid;
  logic        trace_ready;
  logic [63:0] trace_seq;
  logic [31:0] trace_instr;
  logic [63:0] trace_pc;
  logic [63:0] trace_pre_pc;
  logic [3:0]  fifo_level;
  logic [63:0] retire_cnt;
  logic [63:0] cycle_cnt;
  logic        halted;
  logic        overflow;
  logic        hang;

  always #5 clk = ~clk;

  commit_trace_buf #(.DEPTH(DEPTH), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .rst(rst), .commit(commit), .commit_instr(commit_instr),
    .commit_pc(commit_pc), .commit_pre_pc(commit_pre_pc),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_seq(trace_seq),
    .trace_instr(trace_instr), .trace_pc(trace_pc), .trace_pre_pc(trace_pre_pc),
    .fifo_level(fifo_level), .retire_cnt(retire_cnt), .cycle_cnt(cycle_cnt),
    .halted(halted), .overflow(overflow), .hang(hang)
  );

  typedef struct {
    logic [63:0] seq;
    logic [63:0] pre_pc;
    logic [63:0] pc;
    logic [31:0] instr;
  } rec_t;

  rec_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   pops_seen = 0;

  // reference model: 0=RUN 1=DRAIN 2=HALTED
  int          m_level;
  int          m_state;
  int          m_wd;
  logic [63:0] m_retire;
  logic [63:0] m_cycle;
  bit          m_ovf;
  bit          m_hang;
  logic [63:0] last_pc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  initial begin : monitor
    rec_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && trace_valid === 1'b1 && trace_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pop: got seq %h want no record", trace_seq);
        end else begin
          e = exp_q.pop_front();
          chk("head_seq", trace_seq, e.seq);
          chk("head_instr", {32'h0, trace_instr}, {32'h0, e.instr});
          chk("head_pc", trace_pc, e.pc);
          chk("head_pre_pc", trace_pre_pc, e.pre_pc);
          pops_seen++;
        end
      end
    end
  end

  task automatic model_clear();
    m_level = 0; m_state = 0; m_wd = 0; m_retire = 0; m_cycle = 0;
    m_ovf = 0; m_hang = 0; last_pc = 0;
    exp_q.delete();
  endtask

  // Drive one cycle, advance the model across the coming edge, then check the visible state.
  task automatic cyc(input bit c, input logic [31:0] ins, input logic [63:0] pc,
                     input bit rdy, input bit rs);
    bit   p_pop, p_ret, p_push;
    int   old_level;
    rec_t r;
    rst = rs; commit = c; commit_instr = ins; commit_pc = pc;
    commit_pre_pc = last_pc; trace_ready = rdy;
    if (!rs) begin
      model_clear();
    end else begin
      p_pop  = (m_level > 0) && rdy;
      p_ret  = (m_state == 0) && c;
      p_push = p_ret && (m_level < DEPTH || p_pop);
      if (p_ret) begin
        if (p_push) begin
          r.seq = m_retire; r.pre_pc = last_pc; r.pc = pc; r.instr = ins;
          exp_q.push_back(r);
        end else begin
          m_ovf = 1;
        end
        m_retire = m_retire + 64'd1;
        last_pc = pc;
      end
      old_level = m_level;
      m_level = m_level + int'(p_push) - int'(p_pop);
      if (m_state != 2) m_cycle = m_cycle + 64'd1;
      if (p_ret) m_wd = 0;
      else if (m_state == 0 && m_wd < WDOG) begin
        m_wd++;
        if (m_wd == WDOG) m_hang = 1;
      end
      if (m_state == 0 && p_ret && ins == EBREAK) m_state = 1;
      else if (m_state == 1 && old_level == 0) m_state = 2;
    end
    @(posedge clk);
    #1;
    chk("fifo_level", 64'(fifo_level), 64'(m_level));
    chk("trace_valid", 64'(trace_valid), 64'(m_level > 0));
    chk("retire_cnt", retire_cnt, m_retire);
    chk("cycle_cnt", cycle_cnt, m_cycle);
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("hang", 64'(hang), 64'(m_hang));
    chk("halted", 64'(halted), 64'(m_state == 2));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] v;
    v = $urandom;
    if (v == EBREAK) v = v ^ 32'h1;
    return v;
  endfunction

  task automatic do_reset();
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, rdy, 1);
  endtask

  initial begin : stimulus
    int          p0;
    logic [63:0] snap;
    rst = 0; commit = 0; commit_instr = 0; commit_pc = 0; commit_pre_pc = 0; trace_ready = 0;
    model_clear();

    do_reset();
    do_reset();
    chk("rst_trace_seq", trace_seq, 64'h0);
    chk("rst_trace_instr", {32'h0, trace_instr}, 64'h0);
    chk("rst_trace_pc", trace_pc, 64'h0);
    chk("rst_trace_pre_pc", trace_pre_pc, 64'h0);

    // basic capture
    p0 = pops_seen;
    cyc(1, rand_instr(), 64'h8000_0000, 1, 1);
    cyc(1, rand_instr(), 64'h8000_0004, 1, 1);
    cyc(1, rand_instr(), 64'h8000_0008, 1, 1);
    idle(3, 1);
    chk("basic_retire", retire_cnt, 64'd3);
    chk("basic_level", 64'(fifo_level), 64'd0);
    chk("basic_pops", 64'(pops_seen - p0), 64'd3);

    // backpressure and overflow
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1, rand_instr(), 64'h8000_0000 + 64'(4 * i), 0, 1);
    chk("ovf_level", 64'(fifo_level), 64'd8);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_retire", retire_cnt, 64'd10);
    p0 = pops_seen;
    idle(10, 1);
    chk("ovf_drain_pops", 64'(pops_seen - p0), 64'd8);

    // full with simultaneous pop, then a drop, then mid-run reset with 4 queued
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1, rand_instr(), 64'h9000_0000 + 64'(4 * i), 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, rand_instr(), 64'h9000_1000 + 64'(4 * i), 1, 1);
    chk("full_pop_ovf", 64'(overflow), 64'd0);
    chk("full_pop_level", 64'(fifo_level), 64'd8);
    cyc(1, rand_instr(), 64'h9000_2000, 0, 1);
    idle(4, 1);
    chk("pre_rst_level", 64'(fifo_level), 64'd4);
    chk("pre_rst_ovf", 64'(overflow), 64'd1);
    do_reset();
    chk("mid_rst_level", 64'(fifo_level), 64'd0);
    chk("mid_rst_valid", 64'(trace_valid), 64'd0);
    chk("mid_rst_retire", retire_cnt, 64'd0);
    chk("mid_rst_cycle", cycle_cnt, 64'd0);
    chk("mid_rst_flags", {61'h0, overflow, hang, halted}, 64'd0);
    chk("mid_rst_seq", trace_seq, 64'd0);
    cyc(1, rand_instr(), 64'hA000_0000, 0, 1);
    chk("post_rst_run", retire_cnt, 64'd1);

    // watchdog
    do_reset();
    cyc(1, rand_instr(), 64'hB000_0000, 1, 1);
    for (int k = 1; k <= WDOG; k++) begin
      cyc(0, 0, 0, 1, 1);
      if (k == WDOG - 1) chk("wdog_before", 64'(hang), 64'd0);
      if (k == WDOG)     chk("wdog_at", 64'(hang), 64'd1);
    end
    cyc(1, rand_instr(), 64'hB000_0004, 1, 1);
    chk("wdog_sticky", 64'(hang), 64'd1);

    // randomized traffic with occasional resets
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else cyc(bit'($urandom_range(0, 1)), rand_instr(), {$urandom, $urandom},
               ($urandom_range(0, 3) != 0), 1);
    end
    idle(DEPTH + 2, 1);
    chk("rand_drained", 64'(exp_q.size()), 64'd0);

    // ebreak halt
    do_reset();
    p0 = pops_seen;
    cyc(1, rand_instr(), 64'hC000_0000, 0, 1);
    cyc(1, rand_instr(), 64'hC000_0004, 0, 1);
    cyc(1, EBREAK,       64'hC000_0008, 0, 1);
    cyc(1, rand_instr(), 64'hC000_000C, 0, 1);
    cyc(1, rand_instr(), 64'hC000_0010, 0, 1);
    for (int i = 0; i < 12 && m_state != 2; i++) cyc(1, rand_instr(), 64'hC000_0100, 1, 1);
    chk("halt_state", 64'(halted), 64'd1);
    chk("halt_retire", retire_cnt, 64'd3);
    chk("halt_pops", 64'(pops_seen - p0), 64'd3);
    snap = cycle_cnt;
    for (int i = 0; i < 5; i++) cyc(1, rand_instr(), 64'hC000_0200, 1, 1);
    chk("halt_cycle_frozen", cycle_cnt, snap);
    chk("halt_still_retire", retire_cnt, 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
